dac_tpl_upack_fifo: RTL and testbench

Elastic buffer between the DMA stream and the JESD204 DAC transport layer, on the link clock domain. Accepts full-width sample words from an AXI-Stream source, stores them in a small FIFO, and returns one word per transport-layer read strobe on `dac_ddata`. Prefills before the first read so that link start-up does not report underflow. On a true underflow, emits zeros and a `dac_dunf` pulse.

---
 rtl/dac_tpl_upack_fifo_if.sv | 21 ++
 rtl/dac_tpl_upack_fifo.sv | 148 ++++++++++++++
 tb/tb_dac_tpl_upack_fifo.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/dac_tpl_upack_fifo_if.sv
// Source-side AXI-Stream handshake into the DAC elastic buffer.
`timescale 1ns/1ps
interface dac_tpl_upack_fifo_if #(
  parameter int unsigned DATA_WIDTH = 128
);
  logic                  s_axis_valid;
  logic                  s_axis_ready;
  logic [DATA_WIDTH-1:0] s_axis_data;

  modport master (
    output s_axis_valid,
    output s_axis_data,
    input  s_axis_ready
  );

  modport slave (
    input  s_axis_valid,
    input  s_axis_data,
    output s_axis_ready
  );
endinterface

// File: rtl/dac_tpl_upack_fifo.sv
// Elastic buffer between the DMA stream and the JESD204 DAC transport layer.
// Prefills to START_LEVEL before serving reads, then returns one word per
// read strobe; a read on an empty buffer yields zero plus a dac_dunf pulse.
`timescale 1ns/1ps
module dac_tpl_upack_fifo #(
  parameter int unsigned DATA_WIDTH   = 128,
  parameter int unsigned NUM_CHANNELS = 2,
  parameter int unsigned ADDR_WIDTH   = 4,
  parameter int unsigned START_LEVEL  = 8
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [NUM_CHANNELS-1:0] enable,
  input  logic [NUM_CHANNELS-1:0] dac_valid,
  dac_tpl_upack_fifo_if.slave     s_axis,
  output logic [DATA_WIDTH-1:0]   dac_ddata,
  output logic                    dac_dunf,
  output logic [ADDR_WIDTH:0]     fifo_level
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_LVL  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] START_LVL = (ADDR_WIDTH+1)'(START_LEVEL);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREFILL,
    ST_RUN
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]     level_q, level_d;
  logic [DATA_WIDTH-1:0]   ddata_q, ddata_d;
  logic                    dunf_q, dunf_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic rd_req;
  logic en_any;
  logic ready;
  logic wr;
  logic store;
  logic pop;
  logic flush;

  // Ready depends only on registered state and level.
  always_comb begin
    ready = (state_q != ST_IDLE) && (level_q != FULL_LVL);
  end

  assign s_axis.s_axis_ready = ready;
  assign dac_ddata           = ddata_q;
  assign dac_dunf            = dunf_q;
  assign fifo_level          = level_q;

  // Next-state, output word and pointer/level bookkeeping.
  always_comb begin
    rd_req   = |(dac_valid & enable);
    en_any   = |enable;
    wr       = s_axis.s_axis_valid & ready;
    state_d  = state_q;
    ddata_d  = ddata_q;
    dunf_d   = 1'b0;
    pop      = 1'b0;
    flush    = 1'b0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;

    case (state_q)
      ST_IDLE: begin
        if (rd_req) ddata_d = '0;
        if (en_any) state_d = ST_PREFILL;
      end
      ST_PREFILL: begin
        if (rd_req) ddata_d = '0;
        if (!en_any) begin
          state_d = ST_IDLE;
          flush   = 1'b1;
        end else if (level_q >= START_LVL) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!en_any) begin
          state_d = ST_IDLE;
          flush   = 1'b1;
        end
        if (rd_req) begin
          if (level_q != '0) begin
            pop     = 1'b1;
            ddata_d = mem_q[rd_ptr_q];
          end else begin
            // Empty: no fall-through of a same-cycle write.
            ddata_d = '0;
            dunf_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        flush   = 1'b1;
      end
    endcase

    store = wr & ~flush;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (store) wr_ptr_d = wr_ptr_q + (ADDR_WIDTH)'(1);
      if (pop)   rd_ptr_d = rd_ptr_q + (ADDR_WIDTH)'(1);
      case ({store, pop})
        2'b10:   level_d = level_q + (ADDR_WIDTH+1)'(1);
        2'b01:   level_d = level_q - (ADDR_WIDTH+1)'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // Control state and registered outputs, asynchronously cleared.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ddata_q  <= '0;
      dunf_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ddata_q  <= ddata_d;
      dunf_q   <= dunf_d;
    end
  end

  // Sample storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (store) mem_q[wr_ptr_q] <= s_axis.s_axis_data;
  end

endmodule

// File: tb/tb_dac_tpl_upack_fifo.sv
// Directed bench for dac_tpl_upack_fifo with a queue-based reference model.
`timescale 1ns/1ps
module tb_dac_tpl_upack_fifo;

  localparam int DW = 128;

  logic          clk;
  logic          resetn;
  logic [1:0]    enable;
  logic [1:0]    dac_valid;
  logic [DW-1:0] dac_ddata;
  logic          dac_dunf;
  logic [4:0]    fifo_level;

  dac_tpl_upack_fifo_if #(.DATA_WIDTH(DW)) s_axis_if ();

  dac_tpl_upack_fifo #(
    .DATA_WIDTH  (DW),
    .NUM_CHANNELS(2),
    .ADDR_WIDTH  (4),
    .START_LEVEL (8)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .enable    (enable),
    .dac_valid (dac_valid),
    .s_axis    (s_axis_if.slave),
    .dac_ddata (dac_ddata),
    .dac_dunf  (dac_dunf),
    .fifo_level(fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a word queue plus a mode (0 idle, 1 prefill, 2 run).
  logic [DW-1:0] mq[$];
  int            m_mode = 0;
  logic [DW-1:0] m_data = '0;
  logic          m_dunf = 1'b0;
  int            m_sz;
  bit            m_rq, m_rdy, m_w;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mq.delete();
      m_mode = 0;
      m_data = '0;
      m_dunf = 1'b0;
    end else begin
      m_sz   = mq.size();
      m_rq   = |(dac_valid & enable);
      m_rdy  = (m_mode != 0) && (m_sz < 16);
      m_w    = s_axis_if.s_axis_valid && m_rdy;
      m_dunf = 1'b0;
      if (m_mode != 2) begin
        if (m_rq) m_data = '0;
        if (enable == 2'b00) begin
          m_mode = 0;
          mq.delete();
        end else begin
          if (m_w) mq.push_back(s_axis_if.s_axis_data);
          if (m_mode == 0) m_mode = 1;
          else if (m_sz >= 8) m_mode = 2;
        end
      end else begin
        if (m_rq) begin
          if (m_sz > 0) m_data = mq.pop_front();
          else begin
            m_data = '0;
            m_dunf = 1'b1;
          end
        end
        if (enable == 2'b00) begin
          m_mode = 0;
          mq.delete();
        end else if (m_w) begin
          mq.push_back(s_axis_if.s_axis_data);
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("ddata", dac_ddata, m_data);
    chk("dunf", DW'(dac_dunf), DW'(m_dunf));
    chk("level", DW'(fifo_level), DW'(mq.size()));
    chk("ready", DW'(s_axis_if.s_axis_ready), DW'((m_mode != 0) && (mq.size() < 16)));
  end

  bit auto_inc;
  bit acc;

  task automatic step();
    acc = s_axis_if.s_axis_valid & s_axis_if.s_axis_ready;
    @(posedge clk);
    #1;
    if (acc && auto_inc) s_axis_if.s_axis_data = s_axis_if.s_axis_data + 1'b1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  localparam logic [DW-1:0] WORD_A = 128'hA5A5_0001_DEAD_BEEF_0123_4567_89AB_CDEF;

  initial begin
    resetn                 = 1'b1;
    enable                 = 2'b00;
    dac_valid              = 2'b00;
    s_axis_if.s_axis_valid = 1'b0;
    s_axis_if.s_axis_data  = '0;
    auto_inc               = 1'b0;
    #1 resetn = 1'b0;
    step();
    step();
    chk("pin_rst_ddata", dac_ddata, '0);
    chk("pin_rst_dunf", DW'(dac_dunf), '0);
    chk("pin_rst_level", DW'(fifo_level), '0);
    chk("pin_rst_ready", DW'(s_axis_if.s_axis_ready), '0);

    // Prefill with continuous source and reads requested throughout.
    resetn                 = 1'b1;
    enable                 = 2'b11;
    dac_valid              = 2'b11;
    s_axis_if.s_axis_valid = 1'b1;
    auto_inc               = 1'b1;
    steps(10);
    chk("pin_prefill_ddata", dac_ddata, '0);
    chk("pin_prefill_level", DW'(fifo_level), 128'd9);
    step();
    chk("pin_first_pop", dac_ddata, 128'd0);
    steps(4);
    chk("pin_pop4", dac_ddata, 128'd4);
    chk("pin_pop4_level", DW'(fifo_level), 128'd9);

    // Fill to full, then one pop frees a slot.
    dac_valid = 2'b00;
    steps(10);
    chk("pin_full_level", DW'(fifo_level), 128'd16);
    chk("pin_full_ready", DW'(s_axis_if.s_axis_ready), '0);
    dac_valid = 2'b11;
    step();
    chk("pin_after_full_level", DW'(fifo_level), 128'd15);
    chk("pin_after_full_ready", DW'(s_axis_if.s_axis_ready), 128'd1);
    chk("pin_after_full_data", dac_ddata, 128'd5);

    // Drain with source stalled, then three underflowing requests.
    s_axis_if.s_axis_valid = 1'b0;
    steps(15);
    chk("pin_drain_data", dac_ddata, 128'd20);
    chk("pin_drain_level", DW'(fifo_level), '0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("pin_unf_dunf", DW'(dac_dunf), 128'd1);
      chk("pin_unf_data", dac_ddata, '0);
    end
    dac_valid = 2'b00;
    step();
    chk("pin_unf_end", DW'(dac_dunf), '0);

    // Simultaneous write and read at level 0.
    auto_inc               = 1'b0;
    s_axis_if.s_axis_data  = WORD_A;
    s_axis_if.s_axis_valid = 1'b1;
    dac_valid              = 2'b11;
    step();
    chk("pin_wr_rd_empty_dunf", DW'(dac_dunf), 128'd1);
    chk("pin_wr_rd_empty_data", dac_ddata, '0);
    chk("pin_wr_rd_empty_level", DW'(fifo_level), 128'd1);
    s_axis_if.s_axis_valid = 1'b0;
    step();
    chk("pin_word_a", dac_ddata, WORD_A);
    chk("pin_word_a_dunf", DW'(dac_dunf), '0);
    dac_valid = 2'b00;

    // Fill to 10 then disable: flush and re-prefill.
    auto_inc               = 1'b1;
    s_axis_if.s_axis_data  = 128'd100;
    s_axis_if.s_axis_valid = 1'b1;
    steps(10);
    chk("pin_lvl10", DW'(fifo_level), 128'd10);
    enable = 2'b00;
    step();
    chk("pin_flush_level", DW'(fifo_level), '0);
    chk("pin_flush_ready", DW'(s_axis_if.s_axis_ready), '0);
    s_axis_if.s_axis_data = 128'd200;
    enable                = 2'b11;
    dac_valid             = 2'b11;
    steps(10);
    chk("pin_reprefill_data", dac_ddata, '0);
    chk("pin_reprefill_level", DW'(fifo_level), 128'd9);
    step();
    chk("pin_reenable_first", dac_ddata, 128'd200);
    steps(3);
    chk("pin_reenable_fourth", dac_ddata, 128'd203);

    // Asynchronous reset in mid-cycle.
    #1 resetn = 1'b0;
    #1;
    chk("pin_async_ddata", dac_ddata, '0);
    chk("pin_async_dunf", DW'(dac_dunf), '0);
    chk("pin_async_level", DW'(fifo_level), '0);
    chk("pin_async_ready", DW'(s_axis_if.s_axis_ready), '0);
    step();
    s_axis_if.s_axis_data = 128'd300;
    resetn                = 1'b1;
    steps(11);
    chk("pin_restart_first", dac_ddata, 128'd300);
    steps(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
